pattern_gen_multi: RTL and testbench

Parametrised successor to the single-mode colour-bar generator. It produces one of four selectable test patterns: colour bars, checkerboard, grey ramp and an animated bouncing box. The block sits between the VGA timing generator (dValid, xCor, yCor) and the RGB output pins. It adds:
- a registered mode switch that takes effect only at frame boundaries;
- a per-frame animation state machine;
- counter-based bar indexing in place of hard-coded comparators.

---
 rtl/pattern_gen_multi.sv | 160 ++++++++++++++++
 tb/tb_pattern_gen_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_multi.sv
// rtl/pattern_gen_multi.sv - four-mode VGA test pattern generator (bars, checker, ramp, bouncing box)
// Optional macro BORDER_EN overrides the outermost active pixels with white.
module pattern_gen_multi #(
  parameter int COLOR_BITS  = 4,
  parameter int COORD_BITS  = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_BARS    = 8,
  parameter int CHECK_SHIFT = 5,
  parameter int BOX_SIZE    = 32
) (
  input  logic                  pixelClk,
  input  logic                  reset,
  input  logic                  dValid,
  input  logic [COORD_BITS-1:0] xCor,
  input  logic [COORD_BITS-1:0] yCor,
  input  logic [1:0]            modeSel,
  output logic [COLOR_BITS-1:0] R,
  output logic [COLOR_BITS-1:0] G,
  output logic [COLOR_BITS-1:0] B,
  output logic [1:0]            modeActive
);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  localparam int RGB_W = 3 * COLOR_BITS;
  localparam logic [COLOR_BITS-1:0] F = '1;
  localparam logic [COLOR_BITS-1:0] Z = '0;
  localparam logic [COORD_BITS-1:0] X_LAST     = COORD_BITS'(H_ACTIVE - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST     = COORD_BITS'(V_ACTIVE - 1);
  localparam logic [COORD_BITS-1:0] BAR_W_LAST = COORD_BITS'(H_ACTIVE / NUM_BARS - 1);
  localparam logic [2:0]            LAST_BAR   = 3'(NUM_BARS - 1);
  localparam logic [COORD_BITS-1:0] X_STOP     = COORD_BITS'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_BITS-1:0] Y_STOP     = COORD_BITS'(V_ACTIVE - BOX_SIZE);
  localparam logic [COORD_BITS:0]   BOX_W      = (COORD_BITS+1)'(BOX_SIZE);
  localparam logic [COORD_BITS-1:0] ONE        = COORD_BITS'(1);

  logic [1:0]            mode_q, cur_mode;
  logic [COORD_BITS-1:0] pix_cnt_q, pix_cnt_d, cur_pix;
  logic [2:0]            bar_idx_q, bar_idx_d, cur_bar;
  logic [COORD_BITS-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  dir_e                  dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [RGB_W-1:0]      rgb_q, rgb_d;
  logic                  fs, fe, line_start, in_box;

  assign line_start = dValid && (xCor == '0);
  assign fs         = line_start && (yCor == '0);
  assign fe         = dValid && (xCor == X_LAST) && (yCor == Y_LAST);
  // A mode request coinciding with frame start applies to that very pixel.
  assign cur_mode   = fs ? modeSel : mode_q;

  // Bar counters hold the position of the next pixel; xCor==0 forces a restart.
  always_comb begin
    cur_pix   = line_start ? '0 : pix_cnt_q;
    cur_bar   = line_start ? '0 : bar_idx_q;
    pix_cnt_d = pix_cnt_q;
    bar_idx_d = bar_idx_q;
    if (dValid) begin
      if (cur_pix == BAR_W_LAST) begin
        pix_cnt_d = '0;
        bar_idx_d = (cur_bar == LAST_BAR) ? cur_bar : 3'(cur_bar + 3'd1);
      end else begin
        pix_cnt_d = cur_pix + ONE;
        bar_idx_d = cur_bar;
      end
    end
  end

  // Box steps one pixel per frame and turns around on the step that lands on an edge.
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (fe) begin
      if (dir_x_q == DIR_POS) begin
        box_x_d = box_x_q + ONE;
        if (box_x_d == X_STOP) dir_x_d = DIR_NEG;
      end else begin
        box_x_d = box_x_q - ONE;
        if (box_x_d == '0) dir_x_d = DIR_POS;
      end
      if (dir_y_q == DIR_POS) begin
        box_y_d = box_y_q + ONE;
        if (box_y_d == Y_STOP) dir_y_d = DIR_NEG;
      end else begin
        box_y_d = box_y_q - ONE;
        if (box_y_d == '0) dir_y_d = DIR_POS;
      end
    end
  end

  assign in_box = ({1'b0, xCor} >= {1'b0, box_x_q}) && ({1'b0, xCor} < {1'b0, box_x_q} + BOX_W) &&
                  ({1'b0, yCor} >= {1'b0, box_y_q}) && ({1'b0, yCor} < {1'b0, box_y_q} + BOX_W);

  always_comb begin
    rgb_d = '0;
    if (dValid) begin
      case (cur_mode)
        MODE_BARS: begin
          case (cur_bar)
            3'd0:    rgb_d = {F, F, F};
            3'd1:    rgb_d = {F, F, Z};
            3'd2:    rgb_d = {Z, F, F};
            3'd3:    rgb_d = {Z, F, Z};
            3'd4:    rgb_d = {F, Z, F};
            3'd5:    rgb_d = {F, Z, Z};
            3'd6:    rgb_d = {Z, Z, F};
            default: rgb_d = {Z, Z, Z};
          endcase
        end
        MODE_CHECK: rgb_d = (xCor[CHECK_SHIFT] ^ yCor[CHECK_SHIFT]) ? {F, F, F} : {Z, Z, Z};
        MODE_RAMP:  rgb_d = {3{xCor[COORD_BITS-1 -: COLOR_BITS]}};
        MODE_BOX:   rgb_d = in_box ? {F, F, F} : {Z, Z, F};
      endcase
`ifdef BORDER_EN
      if ((xCor == '0) || (xCor == X_LAST) || (yCor == '0) || (yCor == Y_LAST))
        rgb_d = {F, F, F};
`endif
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      mode_q    <= MODE_BARS;
      pix_cnt_q <= '0;
      bar_idx_q <= '0;
      box_x_q   <= '0;
      box_y_q   <= '0;
      dir_x_q   <= DIR_POS;
      dir_y_q   <= DIR_POS;
      rgb_q     <= '0;
    end else begin
      mode_q    <= cur_mode;
      pix_cnt_q <= pix_cnt_d;
      bar_idx_q <= bar_idx_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      rgb_q     <= rgb_d;
    end
  end

  assign R          = rgb_q[RGB_W-1 -: COLOR_BITS];
  assign G          = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign B          = rgb_q[COLOR_BITS-1:0];
  assign modeActive = mode_q;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// tb/tb_pattern_gen_multi.sv - scoreboard bench for pattern_gen_multi
module tb_pattern_gen_multi;

  logic       pixelClk;
  logic       reset;
  logic       dValid;
  logic [9:0] xCor;
  logic [9:0] yCor;
  logic [1:0] modeSel;
  logic [3:0] R, G, B;
  logic [1:0] modeActive;

  pattern_gen_multi dut (
    .pixelClk   (pixelClk),
    .reset      (reset),
    .dValid     (dValid),
    .xCor       (xCor),
    .yCor       (yCor),
    .modeSel    (modeSel),
    .R          (R),
    .G          (G),
    .B          (B),
    .modeActive (modeActive)
  );

  initial pixelClk = 1'b0;
  always #5 pixelClk = ~pixelClk;

  typedef struct {
    bit         chk;
    bit         chk_mode;
    logic [11:0] rgb;
    logic [1:0]  mode;
    int          id;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_bad = 0;
  int         vec_id = 0;
  bit         rst_v = 1'b0;
  logic [11:0] bar_rgb [8];

  task automatic drive(input bit dv, input int x, input int y, input logic [1:0] ms,
                       input bit chk, input bit chk_m, input logic [11:0] rgb, input logic [1:0] m);
    exp_t e;
    @(negedge pixelClk);
    reset   = rst_v;
    dValid  = dv;
    xCor    = 10'(x);
    yCor    = 10'(y);
    modeSel = ms;
    e.chk = chk; e.chk_mode = chk_m; e.rgb = rgb; e.mode = m; e.id = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  task automatic pix(input int x, input int y, input logic [1:0] ms, input logic [11:0] rgb);
    drive(1'b1, x, y, ms, 1'b1, 1'b0, rgb, 2'd0);
  endtask

  task automatic pixm(input int x, input int y, input logic [1:0] ms, input logic [11:0] rgb, input logic [1:0] m);
    drive(1'b1, x, y, ms, 1'b1, 1'b1, rgb, m);
  endtask

  task automatic go(input int x, input int y, input logic [1:0] ms);
    drive(1'b1, x, y, ms, 1'b0, 1'b0, 12'h000, 2'd0);
  endtask

  task automatic blank(input int x, input int y, input logic [1:0] ms);
    drive(1'b0, x, y, ms, 1'b1, 1'b0, 12'h000, 2'd0);
  endtask

  task automatic frame_end(input int n);
    for (int i = 0; i < n; i++) go(639, 479, 2'd3);
  endtask

  always @(posedge pixelClk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk) begin
        n_vec++;
        if ({R, G, B} !== mon_e.rgb) begin
          n_bad++;
          $display("FAIL vec%0d rgb: got %03h expected %03h", mon_e.id, {R, G, B}, mon_e.rgb);
        end
      end
      if (mon_e.chk_mode) begin
        n_vec++;
        if (modeActive !== mon_e.mode) begin
          n_bad++;
          $display("FAIL vec%0d modeActive: got %0d expected %0d", mon_e.id, modeActive, mon_e.mode);
        end
      end
    end
  end

  initial begin
    bar_rgb[0] = 12'hFFF; bar_rgb[1] = 12'hFF0; bar_rgb[2] = 12'h0FF; bar_rgb[3] = 12'h0F0;
    bar_rgb[4] = 12'hF0F; bar_rgb[5] = 12'hF00; bar_rgb[6] = 12'h00F; bar_rgb[7] = 12'h000;
    reset = 1'b1; dValid = 1'b0; xCor = '0; yCor = '0; modeSel = 2'd0;

    // reset with active video and a pending mode request
    rst_v = 1'b1;
    for (int i = 0; i < 3; i++) pixm(0, 0, 2'd2, 12'h000, 2'd0);
    rst_v = 1'b0;

    // bars over a full line
    pixm(0, 0, 2'd0, 12'hFFF, 2'd0);
    for (int x = 1; x < 640; x++) pix(x, 0, 2'd0, bar_rgb[(x / 80 > 7) ? 7 : x / 80]);
    blank(100, 1, 2'd0);

    // mode request mid-frame is deferred to the next frame start
    for (int x = 0; x < 100; x++) begin
      if (x == 50) pixm(x, 100, 2'd2, 12'hFFF, 2'd0);
      else pix(x, 100, 2'd2, (x < 80) ? 12'hFFF : 12'hFF0);
    end
    pixm(0, 0, 2'd2, 12'h000, 2'd2);
    pix(64, 0, 2'd2, 12'h111);
    pix(320, 5, 2'd2, 12'h555);
    pix(639, 0, 2'd2, 12'h999);
    blank(639, 0, 2'd2);

    // checkerboard
    pixm(0, 0, 2'd1, 12'h000, 2'd1);
    pix(31, 0, 2'd1, 12'h000);
    pix(32, 0, 2'd1, 12'hFFF);
    pix(32, 32, 2'd1, 12'h000);
    pix(31, 32, 2'd1, 12'hFFF);
    pix(64, 64, 2'd1, 12'h000);
    pixm(96, 0, 2'd3, 12'hFFF, 2'd1);

    // bouncing box
    pixm(0, 0, 2'd3, 12'hFFF, 2'd3);
    pix(31, 31, 2'd3, 12'hFFF);
    pix(32, 0, 2'd3, 12'h00F);
    pix(0, 32, 2'd3, 12'h00F);
    frame_end(1);
    pix(0, 1, 2'd3, 12'h00F);
    pix(1, 1, 2'd3, 12'hFFF);
    pix(32, 32, 2'd3, 12'hFFF);
    pix(33, 1, 2'd3, 12'h00F);
    frame_end(447);
    pix(448, 448, 2'd3, 12'hFFF);
    pix(448, 447, 2'd3, 12'h00F);
    pix(447, 448, 2'd3, 12'h00F);
    frame_end(1);
    pix(449, 447, 2'd3, 12'hFFF);
    pix(449, 446, 2'd3, 12'h00F);
    frame_end(159);
    pix(608, 288, 2'd3, 12'hFFF);
    pix(607, 288, 2'd3, 12'h00F);
    pix(639, 319, 2'd3, 12'hFFF);
    pix(639, 320, 2'd3, 12'h00F);
    pix(608, 287, 2'd3, 12'h00F);
    frame_end(1);
    pix(607, 287, 2'd3, 12'hFFF);
    pix(639, 287, 2'd3, 12'h00F);
    pix(638, 318, 2'd3, 12'hFFF);
    pix(638, 319, 2'd3, 12'h00F);

    // reset in the middle of a frame
    pixm(0, 0, 2'd1, 12'h000, 2'd1);
    rst_v = 1'b1;
    pixm(40, 40, 2'd1, 12'h000, 2'd0);
    pixm(40, 40, 2'd1, 12'h000, 2'd0);
    rst_v = 1'b0;
    pixm(40, 40, 2'd1, 12'hFFF, 2'd0);
    pixm(0, 0, 2'd3, 12'hFFF, 2'd3);
    pix(32, 0, 2'd3, 12'h00F);
    pix(31, 31, 2'd3, 12'hFFF);

    repeat (3) @(negedge pixelClk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
